// File: rtl/bcd_scan_driver_if.sv
// Bus between the binary source and the BCD scan driver: load request and value
// in, busy/overflow status and the multiplexed digit/select outputs back.
interface bcd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
);
  logic [BIN_WIDTH-1:0]  i_Value;
  logic                  i_Load;
  logic                  o_Busy;
  logic                  o_Overflow;
  logic [3:0]            o_BCD;
  logic [NUM_DIGITS-1:0] o_Digit_Sel;

  modport master (
    output i_Value, i_Load,
    input  o_Busy, o_Overflow, o_BCD, o_Digit_Sel
  );

  modport slave (
    input  i_Value, i_Load,
    output o_Busy, o_Overflow, o_BCD, o_Digit_Sel
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed digit scanner.
// Optional macro LEADING_ZERO_BLANK_EN disables the select for leading-zero digit slots.
module bcd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  bcd_scan_driver_if.slave   bus
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL  = pow10(NUM_DIGITS) - 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(BIN_WIDTH);
  localparam logic [PW-1:0]   PRESC_TOP = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_TOP   = IW'(NUM_DIGITS - 1);

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state_q, state_d;
  logic [BIN_WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]         scratch_q, scratch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [SW-1:0]         display_q, display_d;
  logic                  overflow_q, overflow_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [3:0]            bcd_q, bcd_d;

  logic                  busy;
  logic                  load_accept;
  logic                  conv_done;
  logic [SW-1:0]         scratch_adj;
  logic [SW-1:0]         scratch_step;
  logic [BIN_WIDTH-1:0]  shift_step;
  logic                  sel_blank;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_Load)          state_d = CONV;
      CONV: if (cnt_q == CW'(1))     state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q == CONV);
    load_accept = (state_q == IDLE) && bus.i_Load;
    conv_done   = (state_q == CONV) && (cnt_q == CW'(1));
  end

  // One double-dabble step: adjust the scratch nibbles, then shift {scratch, shift} left.
  assign scratch_adj  = dabble_adjust(scratch_q);
  assign scratch_step = {scratch_adj[SW-2:0], shift_q[BIN_WIDTH-1]};
  assign shift_step   = {shift_q[BIN_WIDTH-2:0], 1'b0};

  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    display_d  = display_q;
    overflow_d = overflow_q;
    if (load_accept) begin
      shift_d    = bus.i_Value;
      scratch_d  = '0;
      cnt_d      = CNT_LOAD;
      ovf_pend_d = (64'(bus.i_Value) > MAX_VAL);
    end else if (busy) begin
      shift_d   = shift_step;
      scratch_d = scratch_step;
      cnt_d     = cnt_q - CW'(1);
      // Display changes only here, so o_BCD never sees a half-converted value.
      if (conv_done) begin
        display_d  = ovf_pend_q ? {SW{1'b1}} : scratch_step;
        overflow_d = ovf_pend_q;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      display_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      display_q  <= display_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Positions above the most significant nonzero digit; digit 0 and overflow never blank.
  function automatic logic [NUM_DIGITS-1:0] blank_of(input logic [SW-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (d[4*k +: 4] != 4'h0) seen = 1'b1;
      m[k] = ~seen;
    end
    return m;
  endfunction

  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  always_comb begin
    blank_d = blank_q;
    if (conv_done) blank_d = ovf_pend_q ? '0 : blank_of(scratch_step);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) blank_q <= '0;
    else          blank_q <= blank_d;
  end

  always_comb begin
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) sel_blank = blank_q[k];
    end
  end
`else
  assign sel_blank = 1'b0;
`endif

  // ---------------- Scanner: prescaler, index, registered select and digit ----------------
  always_comb begin
    presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_TOP) idx_d = (idx_q == IDX_TOP) ? '0 : idx_q + IW'(1);
    sel_d = '0;
    bcd_d = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        sel_d[k] = ~sel_blank;
        bcd_d    = display_q[4*k +: 4];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= NUM_DIGITS'(1);
      bcd_q   <= 4'h0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.o_Busy      = busy;
  assign bus.o_Overflow  = overflow_q;
  assign bus.o_BCD       = bcd_q;
  assign bus.o_Digit_Sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver: decimal-arithmetic reference model checked every cycle,
// plus hand-computed slot expectations.
module tb_bcd_scan_driver;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;
  localparam longint MAXV = 9999;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_driver_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus ();

  bcd_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .SCAN_DIV(SD)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: displayed number, overflow flag, edges since reset, conversion timer.
  longint m_val = 0, m_prev_val = 0, m_pend = 0;
  bit     m_ovf = 0, m_prev_ovf = 0;
  int     m_t = 0, m_busy_rem = 0;

  function automatic longint p10(input int k);
    longint p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int digit_of(input longint v, input bit ovf, input int k);
    if (ovf) return 15;
    return int'((v / p10(k)) % 10);
  endfunction

  function automatic bit blanked(input longint v, input bit ovf, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    return !ovf && (k > 0) && (v < p10(k));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_prev_val = 0; m_ovf = 0; m_prev_ovf = 0;
      m_t = 0; m_busy_rem = 0; m_pend = 0;
    end else begin
      m_prev_val = m_val;
      m_prev_ovf = m_ovf;
      if (m_busy_rem > 0) begin
        m_busy_rem--;
        if (m_busy_rem == 0) begin
          m_val = m_pend;
          m_ovf = (m_pend > MAXV);
        end
      end else if (bus.i_Load) begin
        m_busy_rem = BW;
        m_pend     = longint'(bus.i_Value);
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    int idx;
    logic [ND-1:0] exp_sel;
    idx     = (m_t / SD) % ND;
    exp_sel = blanked(m_prev_val, m_prev_ovf, idx) ? '0 : ND'(1) << idx;
    check("model_busy", bus.o_Busy, (m_busy_rem > 0));
    check("model_ovf",  bus.o_Overflow, m_ovf);
    check("model_sel",  bus.o_Digit_Sel, exp_sel);
    check("model_bcd",  bus.o_BCD, digit_of(m_prev_val, m_prev_ovf, idx));
  end

  task automatic load(input int v);
    @(posedge clk); #2;
    bus.i_Value = BW'(v);
    bus.i_Load  = 1'b1;
    @(posedge clk); #2;
    bus.i_Load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_Busy) check(name, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_slot(input string name, input int sel, input int bcd);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_Digit_Sel !== ND'(sel) && n < 4 * SD + 4) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sel"}, bus.o_Digit_Sel, sel);
    check(name, bus.o_BCD, bcd);
  endtask

  initial begin
    int cnt;
    bus.i_Value = '0;
    bus.i_Load  = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_sel",  bus.o_Digit_Sel, 1);
    check("rst_bcd",  bus.o_BCD, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_ovf",  bus.o_Overflow, 0);

`ifndef LEADING_ZERO_BLANK_EN
    for (int s = 1; s <= 4; s++) begin
      repeat (SD) @(negedge clk);
      check("scan_sel", bus.o_Digit_Sel, 1 << (s % 4));
      check("scan_bcd", bus.o_BCD, 0);
    end

    load(1234);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_Busy) cnt++;
    end
    check("busy_len", cnt, 14);
    expect_slot("d1234_0", 1, 4);
    expect_slot("d1234_1", 2, 3);
    expect_slot("d1234_2", 4, 2);
    expect_slot("d1234_3", 8, 1);
    check("d1234_ovf", bus.o_Overflow, 0);

    load(9999);
    wait_idle("idle_9999");
    expect_slot("d9999_0", 1, 9);
    expect_slot("d9999_3", 8, 9);

    load(10000);
    wait_idle("idle_10000");
    expect_slot("ovf_0", 1, 15);
    expect_slot("ovf_3", 8, 15);
    check("ovf_flag", bus.o_Overflow, 1);

    load(5);
    wait_idle("idle_5");
    expect_slot("d5_0", 1, 5);
    expect_slot("d5_1", 2, 0);
    check("d5_ovf", bus.o_Overflow, 0);

    load(1234);
    repeat (2) @(posedge clk);
    load(42);
    wait_idle("idle_ign");
    expect_slot("ign_0", 1, 4);
    expect_slot("ign_3", 8, 1);
    load(42);
    wait_idle("idle_42");
    expect_slot("d42_0", 1, 2);
    expect_slot("d42_1", 2, 4);
    expect_slot("d42_2", 4, 0);

    load(8765);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_busy", bus.o_Busy, 0);
    check("mrst_sel",  bus.o_Digit_Sel, 1);
    check("mrst_bcd",  bus.o_BCD, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mrst_idle", bus.o_Busy, 0);
    expect_slot("mrst_0", 1, 0);
    expect_slot("mrst_3", 8, 0);
`else
    for (int s = 1; s <= 4; s++) begin
      repeat (SD) @(negedge clk);
      check("blank0_sel", bus.o_Digit_Sel, (s % 4 == 0) ? 1 : 0);
    end
    load(7);
    wait_idle("idle_7");
    expect_slot("b7_0", 1, 7);
    for (int s = 1; s <= 3; s++) begin
      repeat (SD) @(negedge clk);
      check("b7_sel", bus.o_Digit_Sel, 0);
      check("b7_bcd", bus.o_BCD, 0);
    end
    load(10000);
    wait_idle("idle_bovf");
    expect_slot("bovf_3", 8, 15);
    load(0);
    wait_idle("idle_b0");
    expect_slot("b0_0", 1, 0);
    repeat (SD) @(negedge clk);
    check("b0_sel", bus.o_Digit_Sel, 0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
